// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central stall/flush sequencer for a 5-stage MIPS pipeline (IF, ID, EX, MEM,
// WB). Resolves taken branches, jumps and load-use hazards, and freezes the
// whole pipeline while a data-memory access is outstanding. A wait that lasts
// too long parks the controller in a sticky TIMEOUT state until software
// clears it.
//
// Parameters:
//   MAX_WAIT  consecutive MEM_WAIT cycles tolerated before TIMEOUT (1..255;
//             values outside the range are clamped)
//   CNT_W     width of the stall statistics counters (HAZ_PERF_CNT_EN only)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_id_rs/if_id_rt   source fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt
//   id_jump             ID instruction is a jump
//   id_ex_mem_read      EX instruction is a load
//   id_ex_rt            destination of the EX-stage load
//   ex_branch_taken     branch in EX resolved taken
//   ex_mem_access       MEM-stage instruction accesses data memory
//   dmem_ready          data memory has completed the access
//   tmo_clear           leaves the TIMEOUT state
//   pc_write, if_id_write, id_ex_write, ex_mem_write   register enables
//   if_id_flush, id_ex_bubble, mem_wb_bubble           NOP/bubble injects
//   mem_timeout         high while in TIMEOUT
//   load_use_cnt, mem_wait_cnt, flush_cnt   saturating stall statistics
//
// Optional feature: define HAZ_PERF_CNT_EN to add the statistics counters and
// their output ports.
//
// Control outputs are combinational from the registered state and the current
// inputs, so every hazard is answered in the cycle it appears.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
   parameter int unsigned MAX_WAIT = 16
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W    = 32
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] if_id_rs,
   input  logic [4:0] if_id_rt,
   input  logic       id_uses_rt,
   input  logic       id_jump,
   input  logic       id_ex_mem_read,
   input  logic [4:0] id_ex_rt,
   input  logic       ex_branch_taken,
   input  logic       ex_mem_access,
   input  logic       dmem_ready,
   input  logic       tmo_clear,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_write,
   output logic       id_ex_bubble,
   output logic       ex_mem_write,
   output logic       mem_wb_bubble,
   output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int unsigned WAIT_W     = 8;
   localparam int unsigned WAIT_SAT   = 255;
   localparam int unsigned WAIT_LIMIT = (MAX_WAIT == 0)        ? 1 :
                                        (MAX_WAIT > WAIT_SAT) ? WAIT_SAT : MAX_WAIT;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

   // Hazard detection on the current ID/EX contents
   logic mem_stall_c;
   logic load_use_c;

   // Response of the RUN rules below the memory stall (branch, load-use, jump)
   logic run_pc_write, run_if_id_write, run_if_id_flush, run_id_ex_bubble;

   // Unmasked control outputs; reset masking is applied at the ports
   logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c;
   logic id_ex_bubble_c, ex_mem_write_c, mem_wb_bubble_c, mem_timeout_c;

   assign mem_stall_c = ex_mem_access && !dmem_ready;

   // A load writing $0 never creates a dependency
   assign load_use_c = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == if_id_rs) ||
                        (id_uses_rt && (id_ex_rt == if_id_rt)));

   // RUN priority chain: taken branch squashes ID, so it beats load-use and jump
   always_comb begin
      run_pc_write     = 1'b1;
      run_if_id_write  = 1'b1;
      run_if_id_flush  = 1'b0;
      run_id_ex_bubble = 1'b0;
      if (ex_branch_taken) begin
         run_if_id_flush  = 1'b1;
         run_id_ex_bubble = 1'b1;
      end else if (load_use_c) begin
         run_pc_write     = 1'b0;
         run_if_id_write  = 1'b0;
         run_id_ex_bubble = 1'b1;
      end else if (id_jump) begin
         run_if_id_flush  = 1'b1;
      end
   end

   // State and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state and control outputs
   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      pc_write_c      = run_pc_write;
      if_id_write_c   = run_if_id_write;
      if_id_flush_c   = run_if_id_flush;
      id_ex_write_c   = 1'b1;
      id_ex_bubble_c  = run_id_ex_bubble;
      ex_mem_write_c  = 1'b1;
      mem_wb_bubble_c = 1'b0;
      mem_timeout_c   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_stall_c) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (ex_mem_access && dmem_ready) begin
               // Access completes: release this cycle under the RUN rules
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               if (wait_cnt_q != WAIT_W'(WAIT_SAT)) begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
               if (wait_cnt_q == WAIT_W'(WAIT_LIMIT)) begin
                  state_d = ST_TIMEOUT;
               end
            end
         end
         ST_TIMEOUT: begin
            mem_timeout_c = 1'b1;
            if (tmo_clear) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase

      // Full freeze: first stall cycle in RUN, every unreleased wait cycle, TIMEOUT
      if (((state_q == ST_RUN) && mem_stall_c) ||
          ((state_q == ST_MEM_WAIT) && !(ex_mem_access && dmem_ready)) ||
          (state_q == ST_TIMEOUT)) begin
         pc_write_c      = 1'b0;
         if_id_write_c   = 1'b0;
         if_id_flush_c   = 1'b0;
         id_ex_write_c   = 1'b0;
         id_ex_bubble_c  = 1'b0;
         ex_mem_write_c  = 1'b0;
         mem_wb_bubble_c = 1'b1;
      end
   end

   // While reset is held the pipeline free-runs with no flushes
   assign pc_write      = rst_n ? pc_write_c      : 1'b1;
   assign if_id_write   = rst_n ? if_id_write_c   : 1'b1;
   assign if_id_flush   = rst_n ? if_id_flush_c   : 1'b0;
   assign id_ex_write   = rst_n ? id_ex_write_c   : 1'b1;
   assign id_ex_bubble  = rst_n ? id_ex_bubble_c  : 1'b0;
   assign ex_mem_write  = rst_n ? ex_mem_write_c  : 1'b1;
   assign mem_wb_bubble = rst_n ? mem_wb_bubble_c : 1'b0;
   assign mem_timeout   = rst_n ? mem_timeout_c   : 1'b0;

`ifdef HAZ_PERF_CNT_EN
   logic             load_use_act, freeze_act, flush_act;
   logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
   logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Classify the active response; a bubble without a flush is a load-use stall
   assign load_use_act = id_ex_bubble_c && !if_id_flush_c;
   assign freeze_act   = mem_wb_bubble_c;
   assign flush_act    = if_id_flush_c;

   // Saturating event counters
   always_comb begin
      load_use_cnt_d = load_use_cnt_q;
      mem_wait_cnt_d = mem_wait_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      if (load_use_act && (load_use_cnt_q != '1)) begin
         load_use_cnt_d = load_use_cnt_q + CNT_W'(1);
      end
      if (freeze_act && (mem_wait_cnt_q != '1)) begin
         mem_wait_cnt_d = mem_wait_cnt_q + CNT_W'(1);
      end
      if (flush_act && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_use_cnt_q <= '0;
         mem_wait_cnt_q <= '0;
         flush_cnt_q    <= '0;
      end else begin
         load_use_cnt_q <= load_use_cnt_d;
         mem_wait_cnt_q <= mem_wait_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign load_use_cnt = load_use_cnt_q;
   assign mem_wait_cnt = mem_wait_cnt_q;
   assign flush_cnt    = flush_cnt_q;
`endif

endmodule
